// File: rtl/uart_tx_feeder_if.sv
// Byte-write and transmitter-handshake bundle for uart_tx_feeder.
// UART_TX_FEEDER_DROP_CNT_EN adds the saturating o_Drop_Count output.
interface uart_tx_feeder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [7:0]        o_Drop_Count;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte,
        output o_Drop_Count
    );
    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte,
        input  o_Drop_Count
    );
`else
    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );
    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );
`endif
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter one frame at a time.
// UART_TX_FEEDER_DROP_CNT_EN adds a saturating count of dropped writes.
module uart_tx_feeder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    uart_tx_feeder_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_ACTIVE = 2'd1,
        S_WAIT_DONE   = 2'd2
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              overflow_q;
    state_t            state;
    logic              tx_dv_q;
    logic [7:0]        tx_byte_q;
    logic              wr_acc;
    logic              wr_drop;
    logic              pop;

    // Full is the registered flag, so a same-cycle pop never rescues a write.
    assign wr_acc  = bus.i_Wr_DV & ~full_q;
    assign wr_drop = bus.i_Wr_DV & full_q;

    // Done is still high on the transmitter's cleanup and first idle cycle.
    assign pop = (state == S_IDLE) && (count != '0) && !bus.i_Tx_Active && !bus.i_Tx_Done;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!wr_acc && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Storage array, cleared on reset so stale bytes never leak out.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr] <= bus.i_Wr_Byte;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
            empty_q <= (count_nxt == '0);
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Launch sequencer: one strobe per frame, then wait for active and done.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= S_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_dv_q   <= 1'b1;
                        tx_byte_q <= mem[rd_ptr];
                        state     <= S_WAIT_ACTIVE;
                    end
                end
                S_WAIT_ACTIVE: begin
                    if (bus.i_Tx_Active) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.i_Tx_Done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            drop_cnt_q <= '0;
        end else if (wr_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.o_Drop_Count = drop_cnt_q;
`endif

    assign bus.o_Full     = full_q;
    assign bus.o_Empty    = empty_q;
    assign bus.o_Count    = count;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Tx_DV    = tx_dv_q;
    assign bus.o_Tx_Byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder driving a behavioural UART transmitter (4 clocks per bit).
module tb_uart_tx_feeder;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CPB    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hold  = 1'b0;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural transmitter: no reset, done high on cleanup and first idle cycle.
    typedef enum int {T_IDLE, T_START, T_DATA, T_STOP, T_CLEAN} tstate_t;
    tstate_t    tx_ts     = T_IDLE;
    logic       tx_serial = 1'b1;
    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    logic [7:0] tx_data   = '0;
    int         tcnt      = 0;
    int         tidx      = 0;

    assign bus.i_Tx_Active = tx_active | hold;
    assign bus.i_Tx_Done   = tx_done;

    always @(posedge clk) begin
        case (tx_ts)
            T_IDLE: begin
                tx_serial <= 1'b1;
                tx_done   <= 1'b0;
                tcnt      <= 0;
                tidx      <= 0;
                if (bus.o_Tx_DV) begin
                    tx_active <= 1'b1;
                    tx_data   <= bus.o_Tx_Byte;
                    tx_ts     <= T_START;
                end
            end
            T_START: begin
                tx_serial <= 1'b0;
                if (tcnt < int'(CPB) - 1) tcnt <= tcnt + 1;
                else begin tcnt <= 0; tx_ts <= T_DATA; end
            end
            T_DATA: begin
                tx_serial <= tx_data[tidx];
                if (tcnt < int'(CPB) - 1) tcnt <= tcnt + 1;
                else begin
                    tcnt <= 0;
                    if (tidx < 7) tidx <= tidx + 1;
                    else tx_ts <= T_STOP;
                end
            end
            T_STOP: begin
                tx_serial <= 1'b1;
                if (tcnt < int'(CPB) - 1) tcnt <= tcnt + 1;
                else begin
                    tcnt      <= 0;
                    tx_done   <= 1'b1;
                    tx_active <= 1'b0;
                    tx_ts     <= T_CLEAN;
                end
            end
            default: begin
                tx_done <= 1'b1;
                tx_ts   <= T_IDLE;
            end
        endcase
    end

    // Serial-line receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh   = '0;
    logic       rx_busy = 1'b0;
    int         rx_cnt  = 0;
    always @(negedge clk) begin
        if (!rx_busy) begin
            if (tx_serial == 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % int'(CPB) == int'(CPB) / 2) begin
                if (rx_cnt / int'(CPB) <= 8) rx_sh[rx_cnt / int'(CPB) - 1] = tx_serial;
                else begin
                    chk("stop_bit", 32'(tx_serial), 32'd1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // Launch-strobe protocol monitor.
    int   dv_pulses     = 0;
    int   last_done_cyc = -1000;
    int   exact_from    = 0;
    logic exact_gap     = 1'b0;
    logic prev_dv       = 1'b0;
    always @(negedge clk) begin
        if (bus.i_Tx_Done) last_done_cyc = cyc;
        if (bus.o_Tx_DV) begin
            dv_pulses++;
            chk("dv_single_cycle", 32'(prev_dv), 32'd0);
            chk("dv_tx_idle", 32'(bus.i_Tx_Active | bus.i_Tx_Done | (tx_ts != T_IDLE)), 32'd0);
            if (exact_gap && dv_pulses > exact_from)
                chk("dv_gap_after_done", 32'(cyc - last_done_cyc), 32'd2);
            else
                chk("dv_gap_min", 32'(cyc - last_done_cyc >= 2), 32'd1);
        end
        prev_dv = bus.o_Tx_DV;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dv"},    32'(bus.o_Tx_DV),    32'd0);
        chk({tag, "_byte"},  32'(bus.o_Tx_Byte),  32'd0);
        chk({tag, "_full"},  32'(bus.o_Full),     32'd0);
        chk({tag, "_empty"}, 32'(bus.o_Empty),    32'd1);
        chk({tag, "_count"}, 32'(bus.o_Count),    32'd0);
        chk({tag, "_ovf"},   32'(bus.o_Overflow), 32'd0);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        chk({tag, "_drop"},  32'(bus.o_Drop_Count), 32'd0);
`endif
    endtask

    task automatic wr(input logic [7:0] b);
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = b;
        @(negedge clk);
        bus.i_Wr_DV   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk("wait_rx_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        int stable = 0;
        while (stable < 3 && k < budget) begin
            @(negedge clk);
            k++;
            if (tx_ts == T_IDLE && !tx_done && bus.o_Empty && !bus.o_Tx_DV) stable++;
            else stable = 0;
        end
        chk("wait_idle_timeout", 32'(stable >= 3), 32'd1);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] b;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic [7:0] drop;
    } vec_t;
    vec_t vecs[DEPTH + 3];

    initial begin
        // Fill table: 18 writes with transmitter held busy, then one idle cycle.
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            vecs[i].wr    = 1'b1;
            vecs[i].b     = 8'hA0 + 8'(i);
            vecs[i].cnt   = (i + 1 > int'(DEPTH)) ? 5'(DEPTH) : 5'(i + 1);
            vecs[i].full  = (i >= int'(DEPTH) - 1);
            vecs[i].empty = 1'b0;
            vecs[i].ovf   = (i >= int'(DEPTH));
            vecs[i].drop  = (i >= int'(DEPTH)) ? 8'(i - int'(DEPTH) + 1) : 8'd0;
        end
        vecs[DEPTH + 2] = '{1'b0, 8'h00, 5'(DEPTH), 1'b1, 1'b0, 1'b1, 8'd2};

        bus.i_Wr_DV   = 1'b0;
        bus.i_Wr_Byte = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: strobe one cycle after the write edge.
        wr(8'h55);
        chk("t1_count_after_wr", 32'(bus.o_Count), 32'd1);
        chk("t1_empty_after_wr", 32'(bus.o_Empty), 32'd0);
        chk("t1_dv_early",       32'(bus.o_Tx_DV), 32'd0);
        @(negedge clk);
        chk("t1_dv",    32'(bus.o_Tx_DV),   32'd1);
        chk("t1_byte",  32'(bus.o_Tx_Byte), 32'h55);
        chk("t1_count", 32'(bus.o_Count),   32'd0);
        chk("t1_empty", 32'(bus.o_Empty),   32'd1);
        @(negedge clk);
        chk("t1_dv_low", 32'(bus.o_Tx_DV), 32'd0);
        wait_rx(1, 200);
        chk("t1_rx", 32'(rx_q[0]), 32'h55);
        wait_idle(200);

        // Burst of five: frames in order, 2-cycle gap after each done.
        exact_from = dv_pulses + 1;
        exact_gap  = 1'b1;
        for (int i = 1; i <= 5; i++) wr(8'(i));
        wait_rx(6, 500);
        for (int i = 1; i <= 5; i++) chk($sformatf("t2_rx%0d", i), 32'(rx_q[i]), 32'(i));
        wait_idle(200);
        exact_gap = 1'b0;
        chk("t2_pulses", 32'(dv_pulses), 32'd6);

        // Reset mid-frame with three bytes queued.
        for (int i = 0; i < 4; i++) wr(8'hE1 + 8'(i));
        begin
            int k = 0;
            while (!tx_active && k < 50) begin @(negedge clk); k++; end
            chk("t3_tx_started", 32'(tx_active), 32'd1);
        end
        chk("t3_queued", 32'(bus.o_Count), 32'd3);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exact_from = dv_pulses;
        exact_gap  = 1'b1;
        wr(8'h77);
        wait_rx(8, 300);
        chk("t3_rx_inflight", 32'(rx_q[6]), 32'hE1);
        chk("t3_rx_next",     32'(rx_q[7]), 32'h77);
        wait_idle(200);
        exact_gap = 1'b0;
        chk("t3_pulses", 32'(dv_pulses), 32'd8);

        // Table: fill past full while the transmitter looks busy.
        hold = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) begin
            bus.i_Wr_DV   = vecs[i].wr;
            bus.i_Wr_Byte = vecs[i].b;
            @(negedge clk);
            chk($sformatf("fill%0d_count", i), 32'(bus.o_Count),    32'(vecs[i].cnt));
            chk($sformatf("fill%0d_full", i),  32'(bus.o_Full),     32'(vecs[i].full));
            chk($sformatf("fill%0d_empty", i), 32'(bus.o_Empty),    32'(vecs[i].empty));
            chk($sformatf("fill%0d_ovf", i),   32'(bus.o_Overflow), 32'(vecs[i].ovf));
`ifdef UART_TX_FEEDER_DROP_CNT_EN
            chk($sformatf("fill%0d_drop", i),  32'(bus.o_Drop_Count), 32'(vecs[i].drop));
`endif
        end
        bus.i_Wr_DV = 1'b0;

        // Full FIFO: write lands on the same edge as the launch pop.
        hold          = 1'b0;
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = 8'hEE;
        @(negedge clk);
        bus.i_Wr_DV = 1'b0;
        chk("t5_count", 32'(bus.o_Count),    32'd15);
        chk("t5_full",  32'(bus.o_Full),     32'd0);
        chk("t5_dv",    32'(bus.o_Tx_DV),    32'd1);
        chk("t5_byte",  32'(bus.o_Tx_Byte),  32'hA0);
        chk("t5_ovf",   32'(bus.o_Overflow), 32'd1);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        chk("t5_drop",  32'(bus.o_Drop_Count), 32'd3);
`endif
        @(negedge clk);
        hold = 1'b1;

        // One accepted write then 300 dropped ones.
        for (int i = 0; i < 301; i++) begin
            bus.i_Wr_DV   = 1'b1;
            bus.i_Wr_Byte = (i == 0) ? 8'hB0 : 8'hCC;
            @(negedge clk);
        end
        bus.i_Wr_DV = 1'b0;
        chk("t6_count", 32'(bus.o_Count), 32'd16);
        chk("t6_full",  32'(bus.o_Full),  32'd1);
`ifdef UART_TX_FEEDER_DROP_CNT_EN
        chk("t6_drop_sat", 32'(bus.o_Drop_Count), 32'd255);
`endif

        // Drain: remaining bytes leave in write order.
        hold = 1'b0;
        wait_rx(25, 2500);
        for (int j = 0; j < 16; j++)
            chk($sformatf("t6_rx%0d", j), 32'(rx_q[8 + j]), 32'(8'hA0 + 8'(j)));
        chk("t6_rx_last", 32'(rx_q[24]), 32'hB0);
        wait_idle(200);
        chk("t6_empty", 32'(bus.o_Empty), 32'd1);
        chk("t6_rx_total", 32'(rx_q.size()), 32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
